// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared widths, state encodings, bit_width positions and
//               store-lane helpers for the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

  localparam int ES_TO_MS_BUS_WD = 103;
  localparam int MS_TO_ES_BUS_WD = 34;

  // bit_width one-hot positions; the reserved bit behaves as a word access
  localparam int BW_BYTE = 0;
  localparam int BW_HALF = 1;
  localparam int BW_WORD = 2;
  localparam int BW_RSVD = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic        is_unsigned;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  bit_width;
    logic [31:0] wdata;
    logic [31:0] pc;
  } es_to_ms_t;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr;
      SIZE_HALF: strb = 4'b0011 << addr;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wdata[7:0]}};
      SIZE_HALF: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline and data-bus signals of the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus;
  logic                       ws_ready;
  logic                       data_req;
  logic                       data_wr;
  logic [1:0]                 data_size;
  logic [3:0]                 data_wstrb;
  logic [31:0]                data_addr;
  logic [31:0]                data_wdata;
  logic                       data_addr_ok;
  logic                       data_data_ok;
  logic [31:0]                data_rdata;

  modport slave (
    input  es_to_ms_bus, ws_ready, data_addr_ok, data_data_ok, data_rdata,
    output ms_to_es_bus, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
  );

  modport master (
    output es_to_ms_bus, ws_ready, data_addr_ok, data_data_ok, data_rdata,
    input  ms_to_es_bus, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
  );

endinterface

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_access_unit_pkg::*;
(
  input  wire logic [31:0] rdata,
  input  wire logic [1:0]  addr,
  input  wire logic [1:0]  size,
  input  wire logic        is_unsigned,
  output logic      [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      SIZE_BYTE: result = is_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: result = is_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:   result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Issues one data-bus transaction per aligned load/store and
//               returns the formatted result to the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         reset,
  mem_access_unit_if.slave  bus
);

  es_to_ms_t   w_es;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_mem_op;
  logic        w_excp_ale;
  logic        w_start;
  logic        w_capture;
  logic [1:0]  w_size;
  logic [31:0] w_load_result;
  logic        w_dcache_ok;
  logic [31:0] w_mem_result;
  logic [1:0]  w_state_nxt;
  logic        w_unused_pc;

  logic [1:0]  r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;

  assign w_es        = es_to_ms_t'(bus.es_to_ms_bus);
  assign w_unused_pc = &{1'b0, w_es.pc, 1'b0};

  assign w_is_half  = w_es.bit_width[BW_HALF];
  assign w_is_word  = w_es.bit_width[BW_WORD] | w_es.bit_width[BW_RSVD];
  assign w_mem_op   = w_es.mem_we | w_es.mem_re;
  assign w_excp_ale = w_mem_op & ((w_is_half & w_es.addr[0]) | (w_is_word & (|w_es.addr[1:0])));
  assign w_size     = w_es.bit_width[BW_BYTE] ? SIZE_BYTE :
                      w_is_half                ? SIZE_HALF : SIZE_WORD;

  assign w_start   = (r_state == S_IDLE) && w_mem_op && !w_excp_ale;
  assign w_capture = ((r_state == S_REQ)  && bus.data_addr_ok && bus.data_data_ok) ||
                     ((r_state == S_WAIT) && bus.data_data_ok);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_REQ;
      S_REQ:  if (bus.data_addr_ok) w_state_nxt = bus.data_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (bus.data_data_ok) w_state_nxt = S_DONE;
      default: if (bus.ws_ready) w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are latched on entry so the bus stays stable through REQ/WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_wstrb    <= 4'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_result   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_wr       <= w_es.mem_we;
        r_size     <= w_size;
        r_unsigned <= w_es.is_unsigned;
        r_wstrb    <= w_es.mem_we ? store_strb(w_size, w_es.addr[1:0]) : 4'h0;
        r_addr     <= w_es.addr;
        r_wdata    <= store_lanes(w_size, w_es.wdata);
      end
      if (w_capture) begin
        r_result <= w_load_result;
      end
    end
  end

  load_align u_load_align (
    .rdata       (bus.data_rdata),
    .addr        (r_addr[1:0]),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .result      (w_load_result)
  );

  always_comb begin
    case (r_state)
      S_IDLE:  w_dcache_ok = !w_start;
      S_DONE:  w_dcache_ok = 1'b1;
      default: w_dcache_ok = 1'b0;
    endcase
  end

  assign w_mem_result = ((r_state == S_DONE) && !r_wr) ? r_result : 32'h0;

  // Reset forces the idle response regardless of what the execute stage presents
  assign bus.ms_to_es_bus = {w_excp_ale & ~reset, w_dcache_ok | reset, w_mem_result};
  assign bus.data_req     = (r_state == S_REQ);
  assign bus.data_wr      = r_wr;
  assign bus.data_size    = r_size;
  assign bus.data_wstrb   = r_wstrb;
  assign bus.data_addr    = r_addr;
  assign bus.data_wdata   = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   hs;
  int   hs0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial hs = 0;
  always @(posedge clk) if (bus.data_req && bus.data_addr_ok) hs = hs + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [102:0] mk(input logic [31:0] addr, input logic uns, input logic we,
                                      input logic re, input logic [3:0] bw, input logic [31:0] wd);
    return {addr, uns, we, re, bw, wd, 32'hC0DE_0000};
  endfunction

  task automatic fast_load(input string tag, input logic [31:0] addr, input logic uns,
                           input logic [3:0] bw, input logic [31:0] rdata, input logic [31:0] exp);
    bus.es_to_ms_bus = mk(addr, uns, 1'b0, 1'b1, bw, 32'h0);
    tick();
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    settle();
    chk(tag, bus.ms_to_es_bus, {2'b01, exp});
    tick();
    bus.es_to_ms_bus = '0;
  endtask

  task automatic fast_store(input string tag, input logic [31:0] addr, input logic [3:0] bw,
                            input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] lanes);
    bus.es_to_ms_bus = mk(addr, 1'b0, 1'b1, 1'b0, bw, wd);
    tick();
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    settle();
    chk({tag, "_strb"}, bus.data_wstrb, strb);
    chk({tag, "_wdata"}, bus.data_wdata, lanes);
    tick();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    settle();
    chk({tag, "_done"}, bus.ms_to_es_bus, 34'h1_0000_0000);
    tick();
    bus.es_to_ms_bus = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.es_to_ms_bus = mk(32'h3001, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0);
    bus.ws_ready     = 1'b1;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    #3;
    chk("rst_ms_bus", bus.ms_to_es_bus, 34'h1_0000_0000);
    chk("rst_req", bus.data_req, 1'b0);
    chk("rst_strb", bus.data_wstrb, 4'h0);
    chk("rst_addr", bus.data_addr, 32'h0);
    bus.es_to_ms_bus = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Signed byte load, addr_ok after one cycle, data_ok two cycles later
    bus.es_to_ms_bus = mk(32'h1003, 1'b0, 1'b0, 1'b1, 4'b0001, 32'h0);
    settle();
    chk("t1_idle_ok", bus.ms_to_es_bus[32], 1'b0);
    chk("t1_idle_req", bus.data_req, 1'b0);
    tick(); settle();
    chk("t1_req", bus.data_req, 1'b1);
    chk("t1_size", bus.data_size, 2'd0);
    chk("t1_addr", bus.data_addr, 32'h1003);
    chk("t1_wr", bus.data_wr, 1'b0);
    chk("t1_strb", bus.data_wstrb, 4'h0);
    chk("t1_req_ok", bus.ms_to_es_bus[32], 1'b0);
    tick(); bus.data_addr_ok = 1'b1; settle();
    chk("t1_req_held", bus.data_req, 1'b1);
    tick(); bus.data_addr_ok = 1'b0; settle();
    chk("t1_wait_req", bus.data_req, 1'b0);
    chk("t1_wait_ok", bus.ms_to_es_bus[32], 1'b0);
    tick(); bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80AA_BBCC; settle();
    chk("t1_wait_ok2", bus.ms_to_es_bus[32], 1'b0);
    tick(); bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; settle();
    chk("t1_done", bus.ms_to_es_bus, 34'h1_FFFF_FF80);
    tick(); bus.es_to_ms_bus = '0; settle();
    chk("t1_idle_after", bus.ms_to_es_bus, 34'h1_0000_0000);

    // Half store at 0x2002
    bus.es_to_ms_bus = mk(32'h2002, 1'b0, 1'b1, 1'b0, 4'b0010, 32'h0000_1234);
    tick(); bus.data_addr_ok = 1'b1; settle();
    chk("t2_wr", bus.data_wr, 1'b1);
    chk("t2_strb", bus.data_wstrb, 4'b1100);
    chk("t2_wdata", bus.data_wdata, 32'h1234_1234);
    chk("t2_size", bus.data_size, 2'd1);
    tick(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF; settle();
    chk("t2_wait_req", bus.data_req, 1'b0);
    tick(); bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; settle();
    chk("t2_done", bus.ms_to_es_bus, 34'h1_0000_0000);
    tick(); bus.es_to_ms_bus = '0;

    // Misaligned word load never reaches the bus
    bus.es_to_ms_bus = mk(32'h3001, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0);
    settle();
    chk("t3_ale", bus.ms_to_es_bus, 34'h3_0000_0000);
    chk("t3_req0", bus.data_req, 1'b0);
    tick(); settle();
    chk("t3_req1", bus.data_req, 1'b0);
    tick(); settle();
    chk("t3_req2", bus.data_req, 1'b0);
    chk("t3_ale_held", bus.ms_to_es_bus, 34'h3_0000_0000);
    bus.es_to_ms_bus = mk(32'h3002, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0);
    settle();
    chk("t3_rsvd_ale", bus.ms_to_es_bus, 34'h3_0000_0000);
    bus.es_to_ms_bus = mk(32'h3001, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0);
    settle();
    chk("t3_half_ale", bus.ms_to_es_bus[33], 1'b1);
    bus.es_to_ms_bus = '0;
    tick();

    // DONE held with ws_ready low must not reissue
    bus.ws_ready = 1'b0;
    hs0 = hs;
    bus.es_to_ms_bus = mk(32'h5000, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0);
    tick(); bus.data_addr_ok = 1'b1; settle();
    chk("t4_req", bus.data_req, 1'b1);
    tick(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
    tick(); bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_hold_bus", bus.ms_to_es_bus, 34'h1_1234_5678);
      chk("t4_hold_req", bus.data_req, 1'b0);
      tick();
    end
    bus.ws_ready = 1'b1; settle();
    chk("t4_release", bus.ms_to_es_bus, 34'h1_1234_5678);
    tick(); bus.es_to_ms_bus = '0; settle();
    chk("t4_idle", bus.ms_to_es_bus, 34'h1_0000_0000);
    chk("t4_handshakes", hs - hs0, 1);

    // Reset in WAIT abandons the access
    bus.es_to_ms_bus = mk(32'h6000, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0);
    tick(); bus.data_addr_ok = 1'b1;
    tick(); bus.data_addr_ok = 1'b0; settle();
    chk("t5_wait", bus.ms_to_es_bus[32], 1'b0);
    #1; reset = 1'b1; bus.es_to_ms_bus = '0; #1;
    chk("t5_rst_bus", bus.ms_to_es_bus, 34'h1_0000_0000);
    chk("t5_rst_req", bus.data_req, 1'b0);
    tick(); reset = 1'b0;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF; settle();
    chk("t5_post_ok", bus.ms_to_es_bus[32], 1'b1);
    tick(); bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; settle();
    chk("t5_ignored", bus.ms_to_es_bus, 34'h1_0000_0000);
    chk("t5_req", bus.data_req, 1'b0);

    // addr_ok and data_ok together, unsigned half
    bus.es_to_ms_bus = mk(32'h4002, 1'b1, 1'b0, 1'b1, 4'b0010, 32'h0);
    tick(); bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBEEF_0000; settle();
    chk("t6_req", bus.data_req, 1'b1);
    tick(); bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; settle();
    chk("t6_done", bus.ms_to_es_bus, 34'h1_0000_BEEF);
    tick(); bus.es_to_ms_bus = '0; settle();
    chk("t6_idle", bus.ms_to_es_bus, 34'h1_0000_0000);

    fast_load("ld_half_s", 32'h7000, 1'b0, 4'b0010, 32'h1234_8001, 32'hFFFF_8001);
    fast_load("ld_byte_u", 32'h7001, 1'b1, 4'b0001, 32'h0000_A500, 32'h0000_00A5);
    fast_load("ld_byte_s", 32'h7002, 1'b0, 4'b0001, 32'h1180_0000, 32'hFFFF_FF80);
    fast_load("ld_half_hi", 32'h7002, 1'b0, 4'b0010, 32'h7FFF_0000, 32'h0000_7FFF);
    fast_load("ld_word", 32'h7004, 1'b0, 4'b0100, 32'h8765_4321, 32'h8765_4321);
    fast_store("st_byte1", 32'h8001, 4'b0001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    fast_store("st_byte3", 32'h8003, 4'b0001, 32'h1234_56CD, 4'b1000, 32'hCDCD_CDCD);
    fast_store("st_half0", 32'h8000, 4'b0010, 32'hFFFF_5A5A, 4'b0011, 32'h5A5A_5A5A);
    fast_store("st_word", 32'h8004, 4'b0100, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 es_to_ms_bus  input  `ES_TO_MS_BUS_WD (103)  packed {addr[31:0], is_unsigned, mem_we, mem_re, bit_width[3:0], wdata[31:0], pc[31:0]}, MSB first; we/re arrive pre-gated by stage valid and exception.
REQ-004 ms_to_es_bus  output  `MS_TO_ES_BUS_WD (34)  packed {excp_ale, dcache_ok, mem_result[31:0]}, MSB first.
REQ-005 ws_ready  input  1  downstream stage accepts the execute-stage result this cycle.
REQ-006 data_req  output  1  bus request valid.
REQ-007 data_wr  output  1  1 = store, 0 = load.
REQ-008 data_size  output  2  0 = byte, 1 = half, 2 = word.
REQ-009 data_wstrb  output  4  store byte enables; 0 on loads.
REQ-010 data_addr  output  32  request address, unmodified addr.
REQ-011 data_wdata  output  32  lane-replicated store data.
REQ-012 data_addr_ok  input  1  request accepted this cycle.
REQ-013 data_data_ok  input  1  response complete this cycle.
REQ-014 data_rdata  input  32  load return word.

Function
REQ-015 bit_width one-hot: [0] byte, [1] half, [2] word, [3] reserved (treated as word).
REQ-016 mem_op = mem_we | mem_re; mem_we and mem_re are never both 1.
REQ-017 excp_ale = mem_op & ((half & addr[0]) | (word & |addr[1:0])); combinational.
REQ-018 FSM states: IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: no mem_op or excp_ale -> stay; dcache_ok = 1, no bus request.
REQ-020 IDLE: mem_op & !excp_ale -> REQ next cycle; dcache_ok = 0.
REQ-021 REQ: data_req = 1, all bus outputs held stable; on data_addr_ok -> WAIT; if data_addr_ok and data_data_ok are asserted together -> DONE.
REQ-022 WAIT: data_req = 0; on data_data_ok, capture the formatted load result and go to DONE.
REQ-023 DONE: dcache_ok = 1, mem_result = captured value; when ws_ready = 1 -> IDLE; otherwise hold DONE and issue no new request.
REQ-024 dcache_ok = 0 in REQ and WAIT.
REQ-025 mem_result = 0 in every state other than DONE, and 0 in DONE for stores.
REQ-026 Minimum latency for an aligned access: request visible on data_req one cycle after it first appears; dcache_ok asserted one cycle after data_data_ok.
REQ-027 Store wstrb by size and addr[1:0]:
  - byte -> 4'b0001 << addr[1:0]
  - half -> 4'b0011 << addr[1:0]
  - word -> 4'b1111
REQ-028 Store wdata replication: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-029 Load formatting: select the byte or half from data_rdata by addr[1:0]; zero-extend if is_unsigned, else sign-extend; word loads pass through.
REQ-030 Each accepted access issues exactly one bus transaction; a request held on es_to_ms_bus while in DONE is never reissued.
REQ-031 A misaligned access never asserts data_req.

Reset
REQ-032 Asynchronous reset: state -> IDLE and captured result -> 0.
REQ-033 During reset, all bus outputs are 0 and ms_to_es_bus = {0, 1, 32'h0}.
REQ-034 Reset mid-transaction abandons the access; any data_data_ok after reset release while in IDLE is ignored.

Structure
REQ-035 `ES_TO_MS_BUS_WD, `MS_TO_ES_BUS_WD, the state encodings and the bit_width bit positions live in define.vh.
REQ-036 Load extraction and extension are in one sub-module, load_align (inputs: rdata, addr[1:0], size, is_unsigned; output: 32-bit result), purely combinational.

Verification
REQ-037 Load byte, addr=0x1003, is_unsigned=0, rdata=0x80AABBCC, addr_ok one cycle after req, data_ok two cycles later -> data_size=0, mem_result=0xFFFFFF80, dcache_ok high exactly in DONE.
REQ-038 Store half, addr=0x2002, wdata=0x00001234 -> data_wstrb=4'b1100, data_wdata=0x12341234, data_wr=1, mem_result=0.
REQ-039 Load word, addr=0x3001 -> excp_ale=1 and dcache_ok=1 in the same cycle, data_req never asserted.
REQ-040 ws_ready=0 for 3 cycles in DONE with the request held -> only one data_req handshake, result stable throughout, IDLE on the cycle after ws_ready=1.
REQ-041 Reset asserted in WAIT, then data_data_ok pulsed after release -> IDLE, dcache_ok=1, result 0, no capture.
REQ-042 addr_ok and data_ok asserted in the same cycle, half load, addr=0x4002, is_unsigned=1, rdata=0xBEEF0000 -> DONE next cycle, mem_result=0x0000BEEF.
